// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit two's-complement adder/subtractor split into
// WIDTH/CHUNK ripple stages, one chunk per clock, one operation per cycle.
// The pipe moves as one unit: a stalled output freezes every stage.
// Each stage keeps only the sum bits it has already produced and the operand
// bits that later stages still need, so the registers shrink in one direction
// and grow in the other as an operation moves down the pipe.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N = WIDTH / CHUNK;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // The whole pipe shifts unless a held result is waiting on the consumer.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtract is a + ~b + ~cin, so cin acts as a borrow-in.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? ~cin : cin;

  for (genvar k = 0; k < N; k++) begin : g_stage
    // RW: operand bits still to be added on entry to this stage.
    // UW: operand bits handed on to the next stage.
    // SW: sum bits complete after this stage.
    localparam int RW = WIDTH - k * CHUNK;
    localparam int UW = RW - CHUNK;
    localparam int SW = (k + 1) * CHUNK;

    logic [RW-1:0]  a_rem;
    logic [RW-1:0]  b_rem;
    logic           c_in;
    logic           v_in;
    logic [CHUNK:0] part;
    logic [SW-1:0]  s_nxt;

    logic           v_q;
    logic           c_q;
    logic [SW-1:0]  s_q;

    if (k == 0) begin : g_head
      assign a_rem = a;
      assign b_rem = b_eff;
      assign c_in  = c_eff;
      assign v_in  = in_valid;
      assign s_nxt = part[CHUNK-1:0];
    end else begin : g_body
      assign a_rem = g_stage[k-1].g_hi.a_hi_q;
      assign b_rem = g_stage[k-1].g_hi.b_hi_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign s_nxt = {part[CHUNK-1:0], g_stage[k-1].s_q};
    end

    assign part = {1'b0, a_rem[CHUNK-1:0]} + {1'b0, b_rem[CHUNK-1:0]} + (CHUNK+1)'(c_in);

    // Stage valid, chunk carry and accumulated low sum bits.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        c_q <= part[CHUNK];
        s_q <= s_nxt;
      end
    end

    if (UW > 0) begin : g_hi
      logic [UW-1:0] a_hi_q;
      logic [UW-1:0] b_hi_q;

      // Operand bits not yet consumed ride along unmodified.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (advance) begin
          a_hi_q <= a_rem[RW-1:CHUNK];
          b_hi_q <= b_rem[RW-1:CHUNK];
        end
      end
    end

    if (k == N - 1) begin : g_tail
      logic ovf_nxt;
      logic ovf_q;

      // Carry into the MSB is a ^ b ^ sum at that bit; overflow is that
      // carry disagreeing with the carry out.
      assign ovf_nxt = a_rem[RW-1] ^ b_rem[RW-1] ^ part[CHUNK-1] ^ part[CHUNK];

      // Signed overflow flag registered alongside the final sum chunk.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= ovf_nxt;
        end
      end
    end
  end

  assign out_valid = g_stage[N-1].v_q;
  assign sum       = g_stage[N-1].s_q;
  assign cout      = g_stage[N-1].c_q;
  assign ovf       = g_stage[N-1].g_tail.ovf_q;

endmodule
